// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised memory behind a valid/ready request and
// response handshake. One transaction is in flight at a time. A programmable
// number of wait states separates request accept from the response.
module data_mem_responder #(
   parameter int XLen    = 32,
   parameter int MemPos  = 1024,
   parameter int Latency = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [31:0]       req_addr_i,
   input  logic              req_we_i,
   input  logic [XLen-1:0]   req_wdata_i,
   input  logic [XLen/8-1:0] req_be_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [XLen-1:0]   rsp_rdata_o,
   output logic              rsp_err_o
);

   localparam int         AddrWidth = $clog2(MemPos);
   localparam int         BeWidth   = XLen / 8;
   localparam logic [3:0] CntInit   = (Latency > 0) ? 4'(Latency - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;

   logic [31:0]          addr_q;
   logic                 we_q;
   logic [XLen-1:0]      wdata_q;
   logic [BeWidth-1:0]   be_q;

   logic                 accept;
   logic                 enter_resp;
   logic [31:0]          op_addr;
   logic                 op_we;
   logic [XLen-1:0]      op_wdata;
   logic [BeWidth-1:0]   op_be;
   logic                 op_err;
   logic [AddrWidth-1:0] op_idx;

   logic [XLen-1:0]      mem [MemPos];

   assign req_ready_o = (state_q == IDLE) && !rst_i;
   assign accept      = req_valid_i && req_ready_o;
   assign rsp_valid_o = (state_q == RESP) && !rst_i;

   // With zero wait states the memory operation happens on the accept edge
   // itself, so the live request bus is used while still in IDLE.
   assign op_addr  = (state_q == IDLE) ? req_addr_i  : addr_q;
   assign op_we    = (state_q == IDLE) ? req_we_i    : we_q;
   assign op_wdata = (state_q == IDLE) ? req_wdata_i : wdata_q;
   assign op_be    = (state_q == IDLE) ? req_be_i    : be_q;

   // The full word address is range-checked so that addresses beyond storage
   // are rejected instead of aliasing onto low words.
   assign op_err = (op_addr[1:0] != 2'b00) || (op_addr[31:2] >= 30'(MemPos));
   assign op_idx = op_addr[AddrWidth+1:2];

   assign enter_resp = !rst_i &&
                       (((state_q == IDLE) && accept && (Latency == 0)) ||
                        ((state_q == WAIT) && (cnt_q == 4'd0)));

   // Next-state and wait-state counter logic.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (Latency == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CntInit;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP: begin
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and counter registers, synchronous reset.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Capture the request payload on accept; only meaningful while in WAIT.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         addr_q  <= req_addr_i;
         we_q    <= req_we_i;
         wdata_q <= req_wdata_i;
         be_q    <= req_be_i;
      end
   end

   // Response data and error, loaded on the edge entering RESP and held after.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
      end else if (enter_resp) begin
         rsp_err_o   <= op_err;
         rsp_rdata_o <= (!op_we && !op_err) ? mem[op_idx] : '0;
      end
   end

   // Byte-enabled storage write on the edge entering RESP.
   always_ff @(posedge clk_i) begin
      // NOTE: storage has no reset; contents survive rst_i and map cleanly onto RAM.
      if (enter_resp && op_we && !op_err) begin
         for (int b = 0; b < BeWidth; b++) begin
            if (op_be[b]) mem[op_idx][b*8 +: 8] <= op_wdata[b*8 +: 8];
         end
      end
   end

endmodule
